multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/multicycle_alu_mul_iter.sv | 76 +++++++
 rtl/multicycle_alu.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the multicycle ALU and the ALU
//                control stage: action codes, FSM state type, datapath
//                width, multiplier iteration count and the single-cycle
//                operation function.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  // Action codes as produced by the ALU control stage; 101-111 are reserved.
  localparam logic [2:0] ACT_AND = 3'b000;
  localparam logic [2:0] ACT_OR  = 3'b001;
  localparam logic [2:0] ACT_ADD = 3'b010;
  localparam logic [2:0] ACT_SUB = 3'b011;
  localparam logic [2:0] ACT_MUL = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Result of every operation that completes in one cycle. Reserved codes
  // (and MUL, which never takes this path) return zero.
  function automatic logic [DATA_W-1:0] single_cycle_op(
    input logic [2:0]        action,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (action)
      ACT_AND: r = a & b;
      ACT_OR:  r = a | b;
      ACT_ADD: r = a + b;
      ACT_SUB: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Radix-2 shift-add multiplier datapath. Holds multiplicand,
//                multiplier, accumulator and iteration counter; performs one
//                iteration per cycle while step is high.
//  Config      : MUL_EARLY_TERM_EN - when defined, the operation finishes on
//                the iteration where the remaining multiplier shifts to zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load            - capture operands, clear accumulator/count
//                step            - perform one iteration this cycle
//                multiplicand    - operand A
//                multiplier      - operand B
//                done            - this cycle's iteration is the last one
//                product         - accumulator value after this iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] mplr_next;
  logic              last_iter;

  assign acc_next  = acc + (mplr[0] ? mcand : '0);
  assign mplr_next = mplr >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Once the shifted multiplier is zero no further partial product can be
  // added, so the accumulator already holds the final low word.
  assign last_iter = (count == CNT_W'(ITER_COUNT - 1)) || (mplr_next == '0);
`else
  assign last_iter = (count == CNT_W'(ITER_COUNT - 1));
`endif

  assign done    = step && last_iter;
  // Exposed combinationally so the top can register the result on the same
  // edge as the final iteration.
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      mcand <= multiplicand;
      mplr  <= multiplier;
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      mcand <= mcand << 1;
      mplr  <= mplr_next;
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu
//  Description : ALU with single-cycle AND/OR/ADD/SUB and a multi-cycle
//                shift-add MUL. Two-state FSM (IDLE/MUL); busy while MUL.
//  Config      : MUL_EARLY_TERM_EN - enables MUL early termination in
//                mul_iter (results identical, latency data dependent).
//  Ports       : clk_i, rst_i    - clock, synchronous active-high reset
//                valid_i         - operation offered this cycle
//                action_i        - operation code (see alu_pkg)
//                data1_i/data2_i - operands A / B
//                flush_i         - abandon in-flight operation
//                result_o        - registered result, held between results
//                zero_o          - result is zero (qualified by valid_o)
//                valid_o         - one-cycle pulse marking a new result
//                busy_o          - MUL in progress, inputs ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        action_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              busy_o
);

  state_t state;
  state_t state_next;

  logic              accept;
  logic              accept_mul;
  logic              accept_alu;
  logic              mul_step;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  // A flush in the offering cycle cancels the acceptance.
  assign accept     = (state == ST_IDLE) && valid_i && !flush_i;
  assign accept_mul = accept && (action_i == ACT_MUL);
  assign accept_alu = accept && (action_i != ACT_MUL);
  assign mul_step   = (state == ST_MUL);

  mul_iter u_mul_iter (
    .clk          (clk_i),
    .rst          (rst_i),
    .load         (accept_mul),
    .step         (mul_step),
    .multiplicand (data1_i),
    .multiplier   (data2_i),
    .done         (mul_done),
    .product      (mul_product)
  );

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_mul)           state_next = ST_MUL;
      ST_MUL:  if (flush_i || mul_done)  state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state == ST_MUL);
  end

  // Result and valid registers. accept_alu only fires in IDLE and mul_done
  // only in MUL, so at most one source updates the result per edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!flush_i) begin
        if (accept_alu) begin
          result_o <= single_cycle_op(action_i, data1_i, data2_i);
          valid_o  <= 1'b1;
        end else if (mul_done) begin
          result_o <= mul_product;
          valid_o  <= 1'b1;
        end
      end
    end
  end

  // Qualified by valid_o so every output reads zero out of reset.
  assign zero_o = valid_o && (result_o == '0);

endmodule
`default_nettype wire
